sccb_writer: RTL

- SCCB (I2C-like, write-only) master for the OV2640. Sits directly downstream of the register-init ROM.
- Takes each 16-bit {reg_addr, reg_value} word while the ROM's valid flag is high and emits a 3-phase write: DEV_ADDR, reg_addr, reg_value.
- Returns a one-cycle completion pulse that advances the ROM index.
- Drives SIO_C and an open-drain-style SIO_D (data + output-enable); the top level builds the tristate.

---
 rtl/sccb_writer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sccb_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sccb_writer : write-only SCCB master that streams ROM words to the OV2640
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module sccb_writer #(
  parameter int         CLK_DIV    = 63,
  parameter logic [7:0] DEV_ADDR   = 8'h60,
  parameter int         PWR_WAIT   = 25000,
  parameter int         GAP_CYCLES = 250,
  parameter int         RESET_WAIT = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        done,
  output logic        busy,
  output logic        init_done,
  output logic        sio_c,
  output logic        sio_d_out,
  output logic        sio_d_oe
);

  localparam int c_wait_max = (PWR_WAIT > GAP_CYCLES + RESET_WAIT) ?
                              PWR_WAIT : (GAP_CYCLES + RESET_WAIT);
  localparam int c_cw = $clog2(c_wait_max + 1);
  localparam int c_dw = $clog2(CLK_DIV);

  localparam logic [c_cw-1:0] c_cnt_one     = c_cw'(1);
  localparam logic [c_cw-1:0] c_pwr_last    = c_cw'(PWR_WAIT - 1);
  localparam logic [c_cw-1:0] c_gap_last    = c_cw'(GAP_CYCLES - 1);
  localparam logic [c_cw-1:0] c_gap_rst_last = c_cw'(GAP_CYCLES + RESET_WAIT - 1);
  localparam logic [c_dw-1:0] c_div_last    = c_dw'(CLK_DIV - 1);
  localparam logic [c_dw-1:0] c_div_one     = c_dw'(1);

  localparam logic [3:0] c_st_pwr   = 4'd0;
  localparam logic [3:0] c_st_hold  = 4'd1;
  localparam logic [3:0] c_st_idle  = 4'd2;
  localparam logic [3:0] c_st_load  = 4'd3;
  localparam logic [3:0] c_st_start = 4'd4;
  localparam logic [3:0] c_st_bit   = 4'd5;
  localparam logic [3:0] c_st_stop  = 4'd6;
  localparam logic [3:0] c_st_gap   = 4'd7;
  localparam logic [3:0] c_st_done  = 4'd8;

  logic [3:0]      r_state;
  logic [c_cw-1:0] r_cnt;
  logic [c_dw-1:0] r_div;
  logic [1:0]      r_q;
  logic [4:0]      r_slot;
  logic [23:0]     r_shift;
  logic            r_bit;
  logic            r_soft_rst;
  logic            r_init_done;
  logic            r_sio_c;
  logic            r_sio_d_out;
  logic            r_sio_d_oe;

  logic            w_bus_active;
  logic            w_tick;
  logic            w_quarter_end;
  logic            w_ack;
  logic [c_cw-1:0] w_gap_last;
  logic            w_scl;
  logic            w_sda;
  logic            w_oe;

  assign w_bus_active  = (r_state == c_st_start) || (r_state == c_st_bit) ||
                         (r_state == c_st_stop);
  assign w_tick        = w_bus_active && (r_div == c_div_last);
  assign w_quarter_end = w_tick && (r_q == 2'd3);
  assign w_ack         = (r_slot == 5'd8) || (r_slot == 5'd17) || (r_slot == 5'd26);
  assign w_gap_last    = r_soft_rst ? c_gap_rst_last : c_gap_last;

  assign done      = (r_state == c_st_done);
  assign busy      = (r_state == c_st_load) || w_bus_active || (r_state == c_st_gap);
  assign init_done = r_init_done;
  assign sio_c     = r_sio_c;
  assign sio_d_out = r_sio_d_out;
  assign sio_d_oe  = r_sio_d_oe;

  // Line levels per quarter; registered below so the pins never glitch.
  always_comb begin
    w_scl = 1'b1;
    w_sda = 1'b1;
    w_oe  = 1'b1;
    case (r_state)
      c_st_start: begin
        w_scl = (r_q != 2'd3);
        w_sda = (r_q < 2'd2);
      end
      c_st_bit: begin
        w_scl = r_q[1];
        w_sda = ((r_q == 2'd0) || w_ack) ? r_sio_d_out : r_bit;
        w_oe  = !(w_ack && (r_q != 2'd0));
      end
      c_st_stop: begin
        w_scl = (r_q != 2'd0);
        w_sda = r_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_pwr;
      r_cnt       <= '0;
      r_div       <= '0;
      r_q         <= '0;
      r_slot      <= '0;
      r_shift     <= '0;
      r_bit       <= 1'b0;
      r_soft_rst  <= 1'b0;
      r_init_done <= 1'b0;
      r_sio_c     <= 1'b1;
      r_sio_d_out <= 1'b1;
      r_sio_d_oe  <= 1'b1;
    end else begin
      r_sio_c     <= w_scl;
      r_sio_d_out <= w_sda;
      r_sio_d_oe  <= w_oe;

      if (w_bus_active) begin
        r_div <= w_tick ? '0 : r_div + c_div_one;
        if (w_tick) begin
          r_q <= r_q + 2'd1;
        end
      end

      case (r_state)
        c_st_pwr: begin
          if (r_cnt == c_pwr_last) begin
            r_cnt   <= '0;
            r_state <= c_st_hold;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        // Two cycles let the ROM index advance and its data register refill.
        c_st_hold: begin
          if (r_cnt == c_cnt_one) begin
            r_cnt   <= '0;
            r_state <= c_st_idle;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        c_st_idle: begin
          if (data_valid) begin
            r_state <= c_st_load;
          end else begin
            r_init_done <= 1'b1;
          end
        end
        c_st_load: begin
          r_shift    <= {DEV_ADDR, data_in};
          r_soft_rst <= (data_in[15:8] == 8'h12) && data_in[7];
          r_div      <= '0;
          r_q        <= '0;
          r_slot     <= '0;
          r_state    <= c_st_start;
        end
        c_st_start: begin
          if (w_quarter_end) begin
            r_state <= c_st_bit;
          end
        end
        c_st_bit: begin
          // Next bit is presented from q1 onward; ack slots leave the shifter alone.
          if (w_tick && (r_q == 2'd0) && !w_ack) begin
            r_bit   <= r_shift[23];
            r_shift <= {r_shift[22:0], 1'b0};
          end
          if (w_quarter_end) begin
            if (r_slot == 5'd26) begin
              r_state <= c_st_stop;
            end else begin
              r_slot <= r_slot + 5'd1;
            end
          end
        end
        c_st_stop: begin
          if (w_quarter_end) begin
            r_cnt   <= '0;
            r_state <= c_st_gap;
          end
        end
        c_st_gap: begin
          if (r_cnt == w_gap_last) begin
            r_cnt   <= '0;
            r_state <= c_st_done;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        c_st_done: begin
          r_state <= c_st_hold;
        end
        default: begin
          r_state <= c_st_pwr;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
